// File: rtl/fp_mult_pipe.sv
// fp_mult_pipe: iterative floating-point multiplier with a valid/ready handshake on
// both sides. The mantissa product is built by shift-add, BITS_PER_CYC multiplier bits
// per cycle. One normalise/round cycle follows. The result is held until it is consumed.
// Subnormal inputs are read as zero, and tiny results are flushed to zero.
module fp_mult_pipe #(
  parameter int EXP_W        = 8,
  parameter int MAN_W        = 23,
  parameter int BITS_PER_CYC = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] in_a,
  input  logic [EXP_W+MAN_W:0] in_b,
  input  logic [1:0]           rnd_mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] data_out,
  output logic [3:0]           flags
);
  localparam int W     = 1 + EXP_W + MAN_W;
  localparam int MW    = MAN_W + 1;                       // mantissa incl. hidden bit
  localparam int N     = (MW + BITS_PER_CYC - 1) / BITS_PER_CYC;
  localparam int MB_W  = N * BITS_PER_CYC;                // zero-padded multiplier width
  localparam int AW    = MW + MB_W;                       // accumulator width
  localparam int PW    = 2 * MW;                          // exact product width
  localparam int EW    = EXP_W + 2;                       // signed exponent, no wrap
  localparam int BIAS  = (1 << (EXP_W - 1)) - 1;
  localparam int EMAX  = (1 << EXP_W) - 1;
  localparam int CNT_W = $clog2(N + 1);

  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MUL, NORM, DONE} state_t;

  // Decide whether the truncated mantissa must be incremented for the chosen mode.
  function automatic logic round_up(input logic [1:0] rm, input logic s,
                                    input logic lsb, input logic g, input logic st);
    case (rm)
      2'd0:    return g & (st | lsb);   // nearest, ties to even
      2'd1:    return 1'b0;             // toward zero
      2'd2:    return ~s & (g | st);    // toward +inf
      default: return s & (g | st);     // toward -inf
    endcase
  endfunction

  // Saturated result on exponent overflow: infinity or largest finite, by mode and sign.
  function automatic logic [W-1:0] ovf_result(input logic s, input logic [1:0] rm);
    if (rm == 2'd0 || (rm == 2'd2 && !s) || (rm == 2'd3 && s))
      return {s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    return {s, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
  endfunction

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [W-1:0]         data_q, data_d;
  logic [3:0]           flags_q, flags_d;
  logic                 sign_q, sign_d;
  logic signed [EW-1:0] exp_q, exp_d;
  logic [1:0]           rnd_q, rnd_d;
  logic [AW-1:0]        mcand_q, mcand_d;
  logic [MB_W-1:0]      mplier_q, mplier_d;
  logic [AW-1:0]        acc_q, acc_d;

  // Operand field decode and classification.
  logic [EXP_W-1:0]     ea, eb;
  logic [MAN_W-1:0]     fa, fb;
  logic                 a_nan, b_nan, a_snan, b_snan, a_inf, b_inf, a_zero, b_zero;
  logic                 sign_in, spec_hit, inf_x_zero;
  logic signed [EW-1:0] exp_in;

  assign ea         = in_a[W-2 -: EXP_W];
  assign eb         = in_b[W-2 -: EXP_W];
  assign fa         = in_a[MAN_W-1:0];
  assign fb         = in_b[MAN_W-1:0];
  assign a_nan      = (&ea) & (|fa);
  assign b_nan      = (&eb) & (|fb);
  assign a_snan     = a_nan & ~fa[MAN_W-1];
  assign b_snan     = b_nan & ~fb[MAN_W-1];
  assign a_inf      = (&ea) & ~(|fa);
  assign b_inf      = (&eb) & ~(|fb);
  assign a_zero     = ~(|ea);                 // subnormals read as zero
  assign b_zero     = ~(|eb);
  assign inf_x_zero = (a_inf & b_zero) | (b_inf & a_zero);
  assign sign_in    = in_a[W-1] ^ in_b[W-1];
  assign spec_hit   = (&ea) | (&eb) | a_zero | b_zero;
  assign exp_in     = EW'(int'(ea) + int'(eb) - BIAS);

  logic [W-1:0] spec_res;
  logic [3:0]   spec_flags;

  // Result for operands that bypass the multiplier (NaN, infinity, zero).
  always_comb begin
    spec_res   = {sign_in, {(W-1){1'b0}}};
    spec_flags = 4'b0000;
    if (a_nan || b_nan || inf_x_zero) begin
      spec_res   = QNAN;
      spec_flags = {a_snan | b_snan | inf_x_zero, 3'b000};
    end else if (a_inf || b_inf) begin
      spec_res = {sign_in, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end
  end

  logic [AW-1:0] partial;

  // Sum of the multiplicand copies selected by the low multiplier bits this cycle.
  always_comb begin
    partial = '0;
    for (int i = 0; i < BITS_PER_CYC; i++)
      if (mplier_q[i]) partial = partial + (mcand_q << i);
  end

  logic [PW-1:0]        prod, pn;
  logic                 top, guard, sticky, inc, carry, nx;
  logic [MAN_W-1:0]     frac, frac_r;
  logic [MW:0]          mant_r;
  logic signed [EW-1:0] e_r;
  logic [W-1:0]         norm_res;
  logic [3:0]           norm_flags;

  // Normalise the product to 1.f, round, renormalise on carry-out, then resolve range.
  always_comb begin
    prod   = acc_q[PW-1:0];
    top    = prod[PW-1];
    pn     = top ? prod : (prod << 1);
    frac   = pn[PW-2 -: MAN_W];
    guard  = pn[PW-2-MAN_W];
    sticky = |pn[PW-3-MAN_W:0];
    inc    = round_up(rnd_q, sign_q, frac[0], guard, sticky);
    mant_r = {1'b0, 1'b1, frac} + {{MW{1'b0}}, inc};
    carry  = mant_r[MW];
    frac_r = carry ? mant_r[MAN_W:1] : mant_r[MAN_W-1:0];
    e_r    = exp_q + $signed({{(EW-1){1'b0}}, top}) + $signed({{(EW-1){1'b0}}, carry});
    nx     = guard | sticky;
    if (int'(e_r) >= EMAX) begin
      norm_res   = ovf_result(sign_q, rnd_q);
      norm_flags = 4'b0101;
    end else if (int'(e_r) <= 0) begin
      norm_res   = {sign_q, {(W-1){1'b0}}};
      norm_flags = 4'b0011;
    end else begin
      norm_res   = {sign_q, e_r[EXP_W-1:0], frac_r};
      norm_flags = {3'b000, nx};
    end
  end

  // Next-state and datapath update for the IDLE/MUL/NORM/DONE sequence.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    data_d   = data_q;
    flags_d  = flags_q;
    sign_d   = sign_q;
    exp_d    = exp_q;
    rnd_d    = rnd_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sign_d   = sign_in;
          exp_d    = exp_in;
          rnd_d    = rnd_mode;
          mcand_d  = AW'({1'b1, fa});
          mplier_d = MB_W'({1'b1, fb});
          acc_d    = '0;
          cnt_d    = '0;
          if (spec_hit) begin
            data_d  = spec_res;
            flags_d = spec_flags;
            state_d = DONE;
          end else begin
            state_d = MUL;
          end
        end
      end
      MUL: begin
        acc_d    = acc_q + partial;
        mcand_d  = mcand_q << BITS_PER_CYC;
        mplier_d = mplier_q >> BITS_PER_CYC;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(N - 1)) state_d = NORM;
      end
      NORM: begin
        data_d  = norm_res;
        flags_d = norm_flags;
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state and the held result; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      flags_q <= flags_d;
    end
  end

  // Operand and accumulator registers; contents only matter once accepted.
  always_ff @(posedge clk) begin
    sign_q   <= sign_d;
    exp_q    <= exp_d;
    rnd_q    <= rnd_d;
    mcand_q  <= mcand_d;
    mplier_q <= mplier_d;
    acc_q    <= acc_d;
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign data_out  = data_q;
  assign flags     = flags_q;

endmodule

// File: tb/tb_fp_mult_pipe.sv
// Self-checking bench for fp_mult_pipe at default parameters (binary32 format).
module tb_fp_mult_pipe;
  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a, in_b;
  logic [1:0]  rnd_mode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] data_out;
  logic [3:0]  flags;

  int checks = 0;
  int errors = 0;

  fp_mult_pipe dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .rnd_mode(rnd_mode), .out_valid(out_valid),
    .out_ready(out_ready), .data_out(data_out), .flags(flags)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference: exact integer product, rounded by comparing the discarded remainder with half an ulp.
  function automatic logic [35:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                          input logic [1:0] rm);
    logic   s, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, nv, nx, up;
    int     ea, eb, e, sh;
    longint ma, mb, m, q, rem, half;
    s      = a[31] ^ b[31];
    ea     = int'(a[30:23]);
    eb     = int'(b[30:23]);
    a_nan  = (ea == 255) && (a[22:0] != 0);
    b_nan  = (eb == 255) && (b[22:0] != 0);
    a_inf  = (ea == 255) && (a[22:0] == 0);
    b_inf  = (eb == 255) && (b[22:0] == 0);
    a_zero = (ea == 0);
    b_zero = (eb == 0);
    if (a_nan || b_nan) begin
      nv = (a_nan && !a[22]) || (b_nan && !b[22]);
      return {32'h7FC00000, nv, 3'b000};
    end
    if ((a_inf && b_zero) || (b_inf && a_zero)) return {32'h7FC00000, 4'b1000};
    if (a_inf || b_inf) return {s, 8'hFF, 23'h0, 4'h0};
    if (a_zero || b_zero) return {s, 31'h0, 4'h0};
    ma = longint'({1'b1, a[22:0]});
    mb = longint'({1'b1, b[22:0]});
    m  = ma * mb;
    e  = ea + eb - 127;
    if (m >= (longint'(1) << 47)) begin
      sh = 24;
      e  = e + 1;
    end else begin
      sh = 23;
    end
    q    = m >> sh;
    rem  = m - (q << sh);
    half = longint'(1) << (sh - 1);
    nx   = (rem != 0);
    case (rm)
      2'd0:    up = (rem > half) || ((rem == half) && q[0]);
      2'd1:    up = 1'b0;
      2'd2:    up = !s && nx;
      default: up = s && nx;
    endcase
    if (up) q = q + 1;
    if (q == (longint'(1) << 24)) begin
      q = q >> 1;
      e = e + 1;
    end
    if (e >= 255) begin
      if (rm == 2'd0 || (rm == 2'd2 && !s) || (rm == 2'd3 && s))
        return {s, 8'hFF, 23'h0, 4'b0101};
      return {s, 8'hFE, 23'h7FFFFF, 4'b0101};
    end
    if (e <= 0) return {s, 31'h0, 4'b0011};
    return {s, 8'(e), 23'(q), 3'b000, nx};
  endfunction

  function automatic int exp_latency(input logic [31:0] a, input logic [31:0] b);
    if (a[30:23] == 8'h00 || a[30:23] == 8'hFF || b[30:23] == 8'h00 || b[30:23] == 8'hFF)
      return 1;
    return 8;
  endfunction

  function automatic logic [31:0] rand_op();
    logic [7:0]  e;
    logic [22:0] f;
    int          pick;
    pick = $urandom_range(0, 19);
    f    = 23'($urandom);
    if (pick == 0)      e = 8'h00;
    else if (pick == 1) e = 8'hFF;
    else if (pick < 6)  e = 8'($urandom_range(1, 254));
    else                e = 8'($urandom_range(97, 157));
    case ($urandom_range(0, 5))
      0:       f = '0;
      1:       f = f & 23'h7F0000;
      default: ;
    endcase
    return {1'($urandom), e, f};
  endfunction

  // Send one operand pair with out_ready high; check latency, result, and return to IDLE.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [1:0] rm,
                        input string tag);
    logic [35:0] expv;
    int          lat;
    expv      = ref_mul(a, b, rm);
    out_ready = 1'b1;
    in_a      = a;
    in_b      = b;
    rnd_mode  = rm;
    in_valid  = 1'b1;
    check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_a     = $urandom;
    in_b     = $urandom;
    rnd_mode = 2'($urandom);
    lat      = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_latency"}, 64'(lat), 64'(exp_latency(a, b)));
    check({tag, "_data"}, 64'(data_out), 64'(expv[35:4]));
    check({tag, "_flags"}, 64'(flags), 64'(expv[3:0]));
    @(posedge clk); #1;
    check({tag, "_released"}, {62'd0, out_valid, in_ready}, 64'b01);
  endtask

  initial begin
    logic [31:0] a, b;
    logic [35:0] expv;
    int          lat;

    reset     = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    rnd_mode  = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_in_ready", 64'(in_ready), 64'd1);
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_data", 64'(data_out), 64'd0);
    check("reset_flags", 64'(flags), 64'd0);
    reset = 1'b0;

    run_op(32'h3FC00000, 32'h40000000, 2'd0, "basic_1p5x2");
    run_op(32'h3F800001, 32'h3F800001, 2'd0, "inexact_rne");
    run_op(32'h3F800001, 32'h3F800001, 2'd1, "inexact_rtz");
    run_op(32'h3F800001, 32'h3F800001, 2'd2, "inexact_rup");
    run_op(32'h3F800001, 32'h3F800001, 2'd3, "inexact_rdn");
    run_op(32'h3F800001, 32'h3FC00000, 2'd0, "tie_odd_rne");
    run_op(32'h3F800003, 32'h3FC00000, 2'd0, "tie_even_rne");
    run_op(32'h7F7FFFFF, 32'h40000000, 2'd0, "ovf_rne");
    run_op(32'h7F7FFFFF, 32'h40000000, 2'd1, "ovf_rtz");
    run_op(32'hFF7FFFFF, 32'h40000000, 2'd2, "ovf_rup_neg");
    run_op(32'h7F800000, 32'h00000000, 2'd0, "inf_x_zero");
    run_op(32'hFF800000, 32'h40000000, 2'd0, "inf_x_fin");
    run_op(32'h7F800001, 32'h3F800000, 2'd0, "snan_in");
    run_op(32'h00800000, 32'h3F000000, 2'd0, "underflow");
    run_op(32'h80000001, 32'h3F800000, 2'd0, "daz_zero");
    run_op(32'h3FFFFFFF, 32'h3FFFFFFF, 2'd2, "round_carry");

    // Hold the result with out_ready low and confirm it stays put.
    a         = 32'h40490FDB;
    b         = 32'hC02DF854;
    expv      = ref_mul(a, b, 2'd0);
    out_ready = 1'b0;
    in_a      = a;
    in_b      = b;
    rnd_mode  = 2'd0;
    in_valid  = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat      = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check("stall_latency", 64'(lat), 64'd8);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("stall_data", 64'(data_out), 64'(expv[35:4]));
      check("stall_flags", 64'(flags), 64'(expv[3:0]));
      check("stall_hs", {62'd0, out_valid, in_ready}, 64'b10);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("stall_release", {62'd0, out_valid, in_ready}, 64'b01);

    // Abort mid-multiply; a valid operand pair offered during reset must be ignored.
    in_a     = 32'h3FC00000;
    in_b     = 32'h40000000;
    rnd_mode = 2'd0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset    = 1'b1;
    in_valid = 1'b1;
    in_a     = 32'h40400000;
    in_b     = 32'h40400000;
    @(posedge clk); #1;
    check("abort_out_valid", 64'(out_valid), 64'd0);
    check("abort_in_ready", 64'(in_ready), 64'd1);
    check("abort_data", 64'(data_out), 64'd0);
    check("abort_flags", 64'(flags), 64'd0);
    reset    = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("no_accept_in_reset", 64'(out_valid), 64'd0);
    end
    run_op(32'h3FC00000, 32'h40000000, 2'd0, "after_abort");

    for (int i = 0; i < 60; i++) begin
      run_op(rand_op(), rand_op(), 2'($urandom), "random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
